// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock with a registered carry between chunks.
// Valid/ready handshakes on both sides; latency is WIDTH/DIGIT cycles from accept to out_valid.
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, cout_q, ovf_q;
    logic [CNTW-1:0]   cnt_q;
    logic              accept, last;
    logic [DIGIT-1:0]  a_chunk, b_chunk;
    logic [DIGIT:0]    chunk_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  if (out_ready) state_d = in_valid ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
        out_valid = (state_q == StDone);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CNTW'(NCHUNK - 1));

    // Constant-index mux keeps every part-select in range, including NCHUNK == 1.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CNTW'(k)) begin
                a_chunk = a_q[k*DIGIT +: DIGIT];
                b_chunk = b_q[k*DIGIT +: DIGIT];
            end
        end
        chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + (DIGIT + 1)'(carry_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt_q   <= '0;
        end else if (state_q == StRun) begin
            for (int k = 0; k < NCHUNK; k++) begin
                if (cnt_q == CNTW'(k)) begin
                    sum_q[k*DIGIT +: DIGIT] <= chunk_sum[DIGIT-1:0];
                end
            end
            carry_q <= chunk_sum[DIGIT];
            if (last) begin
                cnt_q  <= '0;
                cout_q <= chunk_sum[DIGIT];
                // The last chunk's top bit is the result MSB.
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) & (chunk_sum[DIGIT-1] != a_q[WIDTH-1]);
            end else begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: directed cases on a 16/4 instance plus random sweeps on
// 16/1, 16/16 and 8/2 instances against an arithmetic reference model.
module tb_chunked_adder;

    logic             clk;
    logic             rst_n;
    logic [3:0]       iv, ordy, subv, cinv;
    logic [3:0][15:0] av, bv;
    wire  [3:0]       ir, ov, coutv, ovfv;
    wire  [3:0][15:0] sumv;
    wire  [7:0]       sum8;

    int n_vec = 0;
    int n_err = 0;

    assign sumv[3] = {8'h00, sum8};

    chunked_adder #(.WIDTH(16), .DIGIT(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(av[0]), .b(bv[0]),
        .sub(subv[0]), .cin(cinv[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sumv[0]),
        .cout(coutv[0]), .ovf(ovfv[0]));
    chunked_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(av[1]), .b(bv[1]),
        .sub(subv[1]), .cin(cinv[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sumv[1]),
        .cout(coutv[1]), .ovf(ovfv[1]));
    chunked_adder #(.WIDTH(16), .DIGIT(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(av[2]), .b(bv[2]),
        .sub(subv[2]), .cin(cinv[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sumv[2]),
        .cout(coutv[2]), .ovf(ovfv[2]));
    chunked_adder #(.WIDTH(8), .DIGIT(2)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a(av[3][7:0]),
        .b(bv[3][7:0]), .sub(subv[3]), .cin(cinv[3]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum(sum8), .cout(coutv[3]), .ovf(ovfv[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {ovf, cout, sum} from integer arithmetic on w-bit operands.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic c);
        longint m, ua, ub, r, sa, sb, sr, rs;
        logic   co, of;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        r  = s ? ua - ub - longint'(c) : ua + ub + longint'(c);
        rs = ((r % m) + m) % m;
        co = s ? (r >= 0) : (r >= m);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = s ? sa - sb - longint'(c) : sa + sb + longint'(c);
        of = (sr < -(m / 2)) || (sr >= m / 2);
        return {of, co, rs[15:0]};
    endfunction

    // Issues one operation, scrambles the inputs after accept, and returns the cycles until
    // out_valid (-1 on timeout). The result is left pending with out_ready low.
    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic c, output int lat);
        int guard;
        av[idx] = a; bv[idx] = b; subv[idx] = s; cinv[idx] = c;
        iv[idx] = 1'b1; ordy[idx] = 1'b0;
        guard = 0;
        while (!ir[idx] && guard < 50) begin
            step();
            guard++;
        end
        step();
        iv[idx] = 1'b0;
        av[idx] = 16'($urandom); bv[idx] = 16'($urandom);
        subv[idx] = 1'($urandom); cinv[idx] = 1'($urandom);
        lat = 0;
        while (!ov[idx] && lat < 50) begin
            step();
            lat++;
        end
        if (!ov[idx]) lat = -1;
    endtask

    task automatic pop(input int idx);
        ordy[idx] = 1'b1;
        step();
        ordy[idx] = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || sumv[i] !== 16'h0 || coutv[i] !== 1'b0 ||
                ovfv[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset dut%0d: ir=%b ov=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                         i, ir[i], ov[i], sumv[i], coutv[i], ovfv[i]);
            end
        end
    endtask

    task automatic check_d0(input string name, input int lat, input logic [15:0] es,
                            input logic ec, input logic eo);
        n_vec++;
        if (lat !== 4 || sumv[0] !== es || coutv[0] !== ec || ovfv[0] !== eo) begin
            n_err++;
            $display("FAIL %s: lat=%0d sum=%h cout=%b ovf=%b, want lat=4 sum=%h cout=%b ovf=%b",
                     name, lat, sumv[0], coutv[0], ovfv[0], es, ec, eo);
        end
    endtask

    task automatic test_directed();
        int lat;
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat); check_d0("add_wrap", lat, 16'h0000, 1, 0);
        pop(0);
        n_vec++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL after_pop: ov=%b ir=%b, want 0 1", ov[0], ir[0]);
        end
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, lat); check_d0("add_ovf", lat, 16'h8000, 0, 1);
        pop(0);
        run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, lat); check_d0("sub_ovf", lat, 16'h7FFF, 1, 1);
        pop(0);
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b0, lat); check_d0("sub_brw", lat, 16'hFFFE, 0, 0);
        pop(0);
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, lat); check_d0("sub_bin", lat, 16'hFFFD, 0, 0);
        pop(0);
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(0, 16'h1357, 16'h2468, 1'b0, 1'b1, lat); check_d0("bp_op", lat, 16'h37C0, 0, 0);
        iv[0] = 1'b1;
        av[0] = 16'h00F0; bv[0] = 16'h000F; subv[0] = 1'b0; cinv[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || sumv[0] !== 16'h37C0 || coutv[0] !== 1'b0 ||
                ovfv[0] !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure c%0d: ov=%b ir=%b sum=%h cout=%b ovf=%b, want 1 0 37c0 0 0",
                         i, ov[0], ir[0], sumv[0], coutv[0], ovfv[0]);
            end
            step();
        end
        ordy[0] = 1'b1;
        #1;
        n_vec++;
        if (ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready: in_ready=%b, want 1", ir[0]);
        end
        step();
        ordy[0] = 1'b0; iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 50) begin
            step();
            lat++;
        end
        check_d0("b2b_op", lat, 16'h00FF, 0, 0);
        pop(0);
    endtask

    task automatic test_reset_mid_op();
        int guard;
        av[0] = 16'hFFFF; bv[0] = 16'hFFFF; subv[0] = 1'b0; cinv[0] = 1'b1; iv[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ov[0] !== 1'b0 || sumv[0] !== 16'h0 || coutv[0] !== 1'b0 || ovfv[0] !== 1'b0 ||
            ir[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: ov=%b sum=%h cout=%b ovf=%b ir=%b, want 0 0000 0 0 1",
                     ov[0], sumv[0], coutv[0], ovfv[0], ir[0]);
        end
        step();
        n_vec++;
        if (ov[0] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: ov=%b, want 0", ov[0]);
        end
        rst_n = 1'b1;
        step();
        run_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0, guard);
        check_d0("post_reset", guard, 16'h2345, 0, 0);
        pop(0);
    endtask

    task automatic test_sweep(input int idx, input int w, input int nchunk);
        logic [15:0] a, b, m16;
        logic        s, c;
        logic [17:0] exp;
        int          lat;
        m16 = 16'((32'd1 << w) - 1);
        for (int n = 0; n < 200; n++) begin
            a = 16'($urandom) & m16;
            b = 16'($urandom) & m16;
            if (n % 10 == 0) a = m16;
            if (n % 10 == 1) b = m16;
            s = 1'($urandom);
            c = 1'($urandom);
            exp = model(w, a, b, s, c);
            run_op(idx, a, b, s, c, lat);
            n_vec++;
            if (lat !== nchunk || sumv[idx] !== exp[15:0] || coutv[idx] !== exp[16] ||
                ovfv[idx] !== exp[17]) begin
                n_err++;
                $display("FAIL sweep w%0d/n%0d a=%h b=%h sub=%b cin=%b: lat=%0d sum=%h cout=%b ovf=%b, want lat=%0d sum=%h cout=%b ovf=%b",
                         w, nchunk, a, b, s, c, lat, sumv[idx], coutv[idx], ovfv[idx], nchunk,
                         exp[15:0], exp[16], exp[17]);
            end
            repeat ($urandom_range(0, 2)) step();
            pop(idx);
        end
    endtask

    initial begin
        iv = '0; ordy = '0; subv = '0; cinv = '0; av = '0; bv = '0;
        rst_n = 1'b0;
        repeat (2) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep(0, 16, 4);
        test_sweep(1, 16, 16);
        test_sweep(2, 16, 1);
        test_sweep(3, 8, 4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
Parametrised multi-cycle adder/subtractor, the sequential successor to the single-bit full-adder cell. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a registered carry flop between cycles. Input and output use valid/ready handshakes so it drops into the datapath between a producer and a consumer. It trades latency (WIDTH/DIGIT cycles) for a short critical path.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per clock cycle; 1 <= DIGIT <= WIDTH.
NCHUNK (localparam), WIDTH/DIGIT, cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands and mode valid.
in_ready  output  1  block can accept an operation.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
sub  input  1  0 = A+B+cin, 1 = A-B-cin (cin acts as borrow-in).
cin  input  1  carry-in (add) or borrow-in (sub).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry-out; in sub mode 1 = no borrow.
ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, chunk counter=0, carry flop=0. Any operation in flight is discarded with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready.
- Accept: on the edge where in_valid & in_ready, latch a, the effective B (b if sub=0, ~b if sub=1), and the initial carry (cin if sub=0, ~cin if sub=1). Set counter=0 and go to RUN.
- RUN: each cycle adds chunk k (bits [k*DIGIT +: DIGIT]) of A and effective B plus the carry flop. Write the result into sum bits of chunk k and update the carry flop. After chunk NCHUNK-1, go to DONE.
- DONE: out_valid=1. cout = final carry. ovf = (A[MSB] == effB[MSB]) & (sum[MSB] != A[MSB]).
- Latency: if accepted at edge T, out_valid rises after edge T+NCHUNK. With NCHUNK=1, it rises after the edge following accept.
- Output handshake: on the edge where out_valid & out_ready, leave DONE. If in_valid is also high that same edge, accept the new operation and go straight to RUN (back-to-back); otherwise go to IDLE.
- Backpressure: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable and no new operation is accepted.
- sum, cout and ovf are only meaningful while out_valid=1. They may change during RUN because chunks are written in place. After the output handshake they hold their last value until the next RUN begins.
- Inputs a, b, sub and cin are sampled only at accept; changes during RUN or DONE have no effect.
- in_valid or out_ready changing while not in a handshake-relevant state is ignored. The block never drops or duplicates a result.

Test Plan:
- WIDTH=16, DIGIT=4: accept a=0xFFFF, b=0x0001, sub=0, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1, cin=0 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Repeat with cin=1 -> sum=0xFFFD.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum/cout/ovf stable and in_ready=0 throughout. Then raise out_ready with in_valid=1 -> new operation accepted on the same edge, next out_valid 4 cycles later, no idle gap.
- Reset mid-operation: deassert rst_n 2 cycles into RUN -> out_valid, sum, cout and ovf go to 0 immediately, in_ready=1. After release, a fresh 0x1234+0x1111 gives sum=0x2345.
- Parameter sweep: DIGIT=1, DIGIT=16 and WIDTH=8/DIGIT=2 with 200 random operand/mode vectors each, checked against a behavioural reference model. Latency = WIDTH/DIGIT in every case.
